// File: rtl/ex_stage_mc.sv
// ex_stage_mc: execute stage combining operand forwarding, a single-cycle ALU,
// conditional-set logic and an iterative shift-add multiplier. Owns the EX/MEM
// result register and handshakes with decode (in_*) and memory (out_*).
module ex_stage_mc #(
  parameter int WIDTH = 16,
  parameter int RA    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [RA-1:0]    src_a,
  input  logic [RA-1:0]    src_b,
  input  logic [WIDTH-1:0] rd_a,
  input  logic [WIDTH-1:0] rd_b,
  input  logic [WIDTH-1:0] imm,
  input  logic             use_imm,
  input  logic [RA-1:0]    dst,
  input  logic             reg_write,
  input  logic             fw1_en,
  input  logic [RA-1:0]    fw1_addr,
  input  logic [WIDTH-1:0] fw1_data,
  input  logic             fw2_en,
  input  logic [RA-1:0]    fw2_addr,
  input  logic [WIDTH-1:0] fw2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_ofl,
  output logic [RA-1:0]    out_dst,
  output logic             out_reg_write
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);
  localparam logic [3:0] OP_MUL = 4'd12;

  typedef enum logic {IDLE, MUL_RUN} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] mcand_q, mplier_q, prod_q;
  logic [RA-1:0]    mdst_q;
  logic             mwr_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_result_q;
  logic             out_ofl_q;
  logic [RA-1:0]    out_dst_q;
  logic             out_wr_q;

  logic [WIDTH-1:0] a_op, b_fwd, b_op;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] diff_w, rol_w, ror_w;
  logic [SHW-1:0]   sh;
  logic [SHW:0]     rsh;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ofl;
  logic             out_free, accept;
  logic [WIDTH-1:0] next_prod, mul_final;

  // Forwarding: EX/MEM source beats MEM/WB source beats the register file.
  assign a_op  = (fw1_en && fw1_addr == src_a) ? fw1_data :
                 (fw2_en && fw2_addr == src_a) ? fw2_data : rd_a;
  assign b_fwd = (fw1_en && fw1_addr == src_b) ? fw1_data :
                 (fw2_en && fw2_addr == src_b) ? fw2_data : rd_b;
  assign b_op  = use_imm ? imm : b_fwd;

  assign sum_w  = {1'b0, a_op} + {1'b0, b_op};
  assign diff_w = a_op - b_op;
  assign sh     = b_op[SHW-1:0];
  // Complementary shift for rotates; shifting by WIDTH yields zero, so sh=0 rotates to A.
  assign rsh    = (SHW+1)'(WIDTH) - {1'b0, sh};
  assign rol_w  = (a_op << sh) | (a_op >> rsh);
  assign ror_w  = (a_op >> sh) | (a_op << rsh);

  // Single-cycle ALU result and signed-overflow flag (MUL handled by the FSM).
  always_comb begin
    alu_res = '0;
    alu_ofl = 1'b0;
    case (op)
      4'd0: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_ofl = (a_op[WIDTH-1] == b_op[WIDTH-1]) && (sum_w[WIDTH-1] != a_op[WIDTH-1]);
      end
      4'd1: begin
        alu_res = diff_w;
        alu_ofl = (a_op[WIDTH-1] != b_op[WIDTH-1]) && (diff_w[WIDTH-1] != a_op[WIDTH-1]);
      end
      4'd2:  alu_res = a_op ^ b_op;
      4'd3:  alu_res = a_op & ~b_op;
      4'd4:  alu_res = rol_w;
      4'd5:  alu_res = a_op << sh;
      4'd6:  alu_res = ror_w;
      4'd7:  alu_res = a_op >> sh;
      4'd8:  alu_res = {{(WIDTH-1){1'b0}}, (a_op == b_op)};
      4'd9:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_op) < $signed(b_op))};
      4'd10: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_op) <= $signed(b_op))};
      4'd11: alu_res = {{(WIDTH-1){1'b0}}, sum_w[WIDTH]};
      4'd13: alu_res = b_op;
      4'd14: alu_res = (a_op << 8) | {{(WIDTH-8){1'b0}}, b_op[7:0]};
      default: alu_res = '0;
    endcase
  end

  assign out_free  = !out_valid_q || out_ready;
  assign in_ready  = (state_q == IDLE) && out_free;
  assign accept    = in_valid && in_ready;
  assign next_prod = prod_q + (mplier_q[0] ? mcand_q : '0);
  // On the last iteration the product is taken straight from the adder;
  // when completion had to wait (counter already 0) the stored product is used.
  assign mul_final = (cnt_q == CW'(1)) ? next_prod : prod_q;

  // Control FSM, multiplier datapath and EX/MEM output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      prod_q       <= '0;
      mdst_q       <= '0;
      mwr_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_ofl_q    <= 1'b0;
      out_dst_q    <= '0;
      out_wr_q     <= 1'b0;
    end else if (flush) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (out_ready) out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              state_q  <= MUL_RUN;
              cnt_q    <= CW'(WIDTH);
              mcand_q  <= a_op;
              mplier_q <= b_op;
              prod_q   <= '0;
              mdst_q   <= dst;
              mwr_q    <= reg_write;
            end else begin
              out_valid_q  <= 1'b1;
              out_result_q <= alu_res;
              out_ofl_q    <= alu_ofl;
              out_dst_q    <= dst;
              out_wr_q     <= reg_write;
            end
          end
        end
        MUL_RUN: begin
          if (cnt_q > CW'(1)) begin
            prod_q   <= next_prod;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CW'(1);
          end else if (out_free) begin
            out_valid_q  <= 1'b1;
            out_result_q <= mul_final;
            out_ofl_q    <= 1'b0;
            out_dst_q    <= mdst_q;
            out_wr_q     <= mwr_q;
            cnt_q        <= '0;
            state_q      <= IDLE;
          end else begin
            prod_q <= mul_final;
            cnt_q  <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid     = out_valid_q;
  assign out_result    = out_result_q;
  assign out_ofl       = out_ofl_q;
  assign out_dst       = out_dst_q;
  assign out_reg_write = out_wr_q;

endmodule

// File: tb/tb_ex_stage_mc.sv
// tb_ex_stage_mc: table-driven single-cycle vectors, directed multi-cycle
// sequences (reset, MUL latency, back-pressure, flush) and a randomized run
// scored against a behavioural model with an in-order expectation queue.
module tb_ex_stage_mc;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [3:0]  op;
  logic [2:0]  src_a, src_b, dst, fw1_addr, fw2_addr;
  logic [15:0] rd_a, rd_b, imm, fw1_data, fw2_data;
  logic        use_imm, reg_write, fw1_en, fw2_en;
  logic        out_valid, out_ready, out_ofl, out_reg_write;
  logic [15:0] out_result;
  logic [2:0]  out_dst;

  int n_pass  = 0;
  int n_total = 0;

  ex_stage_mc #(.WIDTH(16), .RA(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src_a(src_a), .src_b(src_b), .rd_a(rd_a), .rd_b(rd_b),
    .imm(imm), .use_imm(use_imm), .dst(dst), .reg_write(reg_write),
    .fw1_en(fw1_en), .fw1_addr(fw1_addr), .fw1_data(fw1_data),
    .fw2_en(fw2_en), .fw2_addr(fw2_addr), .fw2_data(fw2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_ofl(out_ofl), .out_dst(out_dst), .out_reg_write(out_reg_write)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [2:0]  src_a, src_b;
    logic [15:0] rd_a, rd_b, imm;
    logic        use_imm;
    logic        fw1_en;
    logic [2:0]  fw1_addr;
    logic [15:0] fw1_data;
    logic        fw2_en;
    logic [2:0]  fw2_addr;
    logic [15:0] fw2_data;
    logic [2:0]  dst;
    logic        reg_write;
    logic [15:0] exp_res;
    logic        exp_ofl;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic        ofl;
    logic [2:0]  dst;
    logic        wr;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t base(input string name, input logic [3:0] o, input logic [15:0] a,
                                input logic [15:0] b, input logic [15:0] er, input logic eo);
    vec_t v;
    v.name = name; v.op = o; v.src_a = 3'd1; v.src_b = 3'd4;
    v.rd_a = a; v.rd_b = 16'h0; v.imm = b; v.use_imm = 1'b1;
    v.fw1_en = 1'b0; v.fw1_addr = 3'd0; v.fw1_data = 16'h0;
    v.fw2_en = 1'b0; v.fw2_addr = 3'd0; v.fw2_data = 16'h0;
    v.dst = o[2:0]; v.reg_write = 1'b1; v.exp_res = er; v.exp_ofl = eo;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    op = v.op; src_a = v.src_a; src_b = v.src_b; rd_a = v.rd_a; rd_b = v.rd_b;
    imm = v.imm; use_imm = v.use_imm; fw1_en = v.fw1_en; fw1_addr = v.fw1_addr;
    fw1_data = v.fw1_data; fw2_en = v.fw2_en; fw2_addr = v.fw2_addr;
    fw2_data = v.fw2_data; dst = v.dst; reg_write = v.reg_write;
  endtask

  // Reference: operation semantics computed with plain integer arithmetic.
  function automatic logic [16:0] model(input int o, input longint a, input longint b);
    longint r, sa, sb2, s;
    int sh;
    logic ofl;
    ofl = 1'b0;
    sa  = (a >= 32768) ? a - 65536 : a;
    sb2 = (b >= 32768) ? b - 65536 : b;
    sh  = int'(b % 16);
    r   = 0;
    case (o)
      0:  begin r = (a + b) % 65536; s = sa + sb2; ofl = (s > 32767) || (s < -32768); end
      1:  begin r = (a - b + 65536) % 65536; s = sa - sb2; ofl = (s > 32767) || (s < -32768); end
      2:  r = a ^ b;
      3:  r = a & (~b & 65535);
      4:  begin r = a; repeat (sh) r = ((r << 1) | (r >> 15)) & 65535; end
      5:  r = (a << sh) & 65535;
      6:  begin r = a; repeat (sh) r = (r >> 1) | ((r & 1) << 15); end
      7:  r = a >> sh;
      8:  r = (sa == sb2) ? 1 : 0;
      9:  r = (sa < sb2) ? 1 : 0;
      10: r = (sa <= sb2) ? 1 : 0;
      11: r = ((a + b) > 65535) ? 1 : 0;
      12: r = (a * b) % 65536;
      13: r = b;
      14: r = ((a << 8) & 65535) | (b & 255);
      default: r = 0;
    endcase
    return {ofl, r[15:0]};
  endfunction

  function automatic logic [15:0] pick(input logic [2:0] src, input logic [15:0] rd,
                                       input logic e1, input logic [2:0] ad1, input logic [15:0] d1,
                                       input logic e2, input logic [2:0] ad2, input logic [15:0] d2);
    if (e1 && ad1 == src) return d1;
    if (e2 && ad2 == src) return d2;
    return rd;
  endfunction

  // Present one single-cycle vector and check the registered result one cycle later.
  task automatic apply_vec(input vec_t v);
    drive(v);
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({v.name, "_in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    chk({v.name, "_valid"}, out_valid, 1);
    chk({v.name, "_result"}, out_result, v.exp_res);
    chk({v.name, "_ofl"}, out_ofl, v.exp_ofl);
    chk({v.name, "_dst"}, {out_reg_write, out_dst}, {v.reg_write, v.dst});
  endtask

  // Issue a MUL and measure edges until the result appears; in_ready must stay low meanwhile.
  task automatic measure_mul(input string name, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] exp);
    int lat, ir_bad;
    drive(base(name, 4'd12, a, b, exp, 1'b0));
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({name, "_accept"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    lat = 0; ir_bad = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) ir_bad++;
      step();
      lat++;
    end
    chk({name, "_latency"}, lat, 16);
    chk({name, "_busy"}, ir_bad, 0);
    chk({name, "_result"}, out_result, exp);
    chk({name, "_ready_after"}, in_ready, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int lat, bad;
    logic [16:0] m;
    logic [15:0] ea, eb;
    exp_t e, held;
    logic hold;

    // ---- vector table ----
    v = base("fwd_fw1", 4'd2, 16'h3333, 16'h0, 16'h1111, 1'b0);
    v.src_a = 3'd2; v.fw1_en = 1'b1; v.fw1_addr = 3'd2; v.fw1_data = 16'h1111;
    v.fw2_en = 1'b1; v.fw2_addr = 3'd2; v.fw2_data = 16'h2222;
    vecs.push_back(v);
    v.name = "fwd_fw2"; v.fw1_en = 1'b0; v.exp_res = 16'h2222; vecs.push_back(v);
    v.name = "fwd_rf"; v.fw2_en = 1'b0; v.exp_res = 16'h3333; vecs.push_back(v);
    v = base("fwd_b", 4'd0, 16'h0001, 16'h0, 16'h0011, 1'b0);
    v.use_imm = 1'b0; v.src_b = 3'd5; v.rd_b = 16'h0999; v.fw1_en = 1'b1; v.fw1_addr = 3'd3;
    v.fw1_data = 16'h7777; v.fw2_en = 1'b1; v.fw2_addr = 3'd5; v.fw2_data = 16'h0010;
    vecs.push_back(v);
    v = base("imm_over_fwd", 4'd13, 16'h0, 16'h00AA, 16'h00AA, 1'b0);
    v.fw1_en = 1'b1; v.fw1_addr = 3'd4; v.fw1_data = 16'h5555; v.reg_write = 1'b0;
    vecs.push_back(v);
    vecs.push_back(base("add_ovf", 4'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b1));
    vecs.push_back(base("sub_ovf", 4'd1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1));
    vecs.push_back(base("sub_plain", 4'd1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0));
    vecs.push_back(base("andn", 4'd3, 16'hF0F0, 16'hFF00, 16'h00F0, 1'b0));
    vecs.push_back(base("rol4", 4'd4, 16'h8001, 16'h0004, 16'h0018, 1'b0));
    vecs.push_back(base("sll15", 4'd5, 16'h0001, 16'h000F, 16'h8000, 1'b0));
    vecs.push_back(base("ror1", 4'd6, 16'h0001, 16'h0001, 16'h8000, 1'b0));
    vecs.push_back(base("srl15", 4'd7, 16'h8000, 16'h001F, 16'h0001, 1'b0));
    vecs.push_back(base("seq", 4'd8, 16'h0005, 16'h0005, 16'h0001, 1'b0));
    vecs.push_back(base("slt_neg", 4'd9, 16'hFFFF, 16'h0001, 16'h0001, 1'b0));
    vecs.push_back(base("slt_pos", 4'd9, 16'h0001, 16'hFFFF, 16'h0000, 1'b0));
    vecs.push_back(base("sle_eq", 4'd10, 16'h0003, 16'h0003, 16'h0001, 1'b0));
    vecs.push_back(base("sco", 4'd11, 16'hFFFF, 16'h0001, 16'h0001, 1'b0));
    vecs.push_back(base("slbi", 4'd14, 16'h0012, 16'h0034, 16'h1234, 1'b0));
    vecs.push_back(base("reserved", 4'd15, 16'h1234, 16'h5678, 16'h0000, 1'b0));

    // ---- reset, including reset in the middle of a MUL ----
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(base("idle", 4'd0, 16'h0, 16'h0, 16'h0, 1'b0));
    step(); step();
    rst = 1'b0;
    chk("reset_valid", out_valid, 0);
    chk("reset_ready", in_ready, 1);
    drive(base("pre_add", 4'd0, 16'h0100, 16'h0200, 16'h0300, 1'b0));
    in_valid = 1'b1; out_ready = 1'b0;
    step();
    drive(base("pre_mul", 4'd12, 16'h0003, 16'h0003, 16'h0009, 1'b0));
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_mid_mul_outs", {out_valid, out_ofl, out_reg_write, out_dst, out_result}, 0);
    chk("rst_mid_mul_ready", in_ready, 1);
    apply_vec(base("add_3_4", 4'd0, 16'h0003, 16'h0004, 16'h0007, 1'b0));

    // ---- table-driven single-cycle ops, back to back ----
    foreach (vecs[i]) apply_vec(vecs[i]);

    // ---- MUL latency and back-to-back MULs ----
    measure_mul("mul_a", 16'h0123, 16'h0045, 16'h4E6F);
    measure_mul("mul_b", 16'hFFFF, 16'hFFFF, 16'h0001);
    step();

    // ---- back-pressure around a completing MUL ----
    drive(base("bp_add", 4'd0, 16'h0001, 16'h0002, 16'h0003, 1'b0));
    in_valid = 1'b1; out_ready = 1'b0;
    #1;
    chk("bp_add_ready", in_ready, 1);
    step();
    chk("bp_add_result", {out_valid, out_result}, {1'b1, 16'h0003});
    drive(base("bp_mul", 4'd12, 16'h0003, 16'h0005, 16'h000F, 1'b0));
    out_ready = 1'b1;
    #1;
    chk("bp_mul_accept", in_ready, 1);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin step(); lat++; end
    chk("bp_mul_latency", lat, 16);
    drive(base("bp_slbi", 4'd14, 16'h00AB, 16'h00CD, 16'hABCD, 1'b0));
    in_valid = 1'b1;
    bad = 0;
    repeat (5) begin
      if (!out_valid || out_result !== 16'h000F || in_ready) bad++;
      step();
    end
    chk("bp_hold", bad, 0);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    chk("bp_release_result", out_result, 16'h000F);
    step();
    in_valid = 1'b0;
    chk("bp_next_result", {out_valid, out_result}, {1'b1, 16'hABCD});
    step();

    // ---- flush during MUL ----
    drive(base("fl_mul", 4'd12, 16'h0007, 16'h0009, 16'h003F, 1'b0));
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (6) step();
    drive(base("fl_add", 4'd0, 16'h0001, 16'h0001, 16'h0002, 1'b0));
    in_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_ready", in_ready, 1);
    bad = 0;
    repeat (20) begin
      if (out_valid) bad++;
      step();
    end
    chk("flush_no_late_result", bad, 0);

    // ---- randomized traffic against the model ----
    hold = 1'b0;
    held = '{default: '0};
    for (int cyc = 0; cyc < 600; cyc++) begin
      op = 4'($urandom_range(0, 15));
      src_a = 3'($urandom_range(0, 7)); src_b = 3'($urandom_range(0, 7));
      rd_a = 16'($urandom); rd_b = 16'($urandom); imm = 16'($urandom);
      use_imm = 1'($urandom_range(0, 1));
      fw1_en = 1'($urandom_range(0, 1)); fw1_addr = 3'($urandom_range(0, 7));
      fw1_data = 16'($urandom);
      fw2_en = 1'($urandom_range(0, 1)); fw2_addr = 3'($urandom_range(0, 7));
      fw2_data = 16'($urandom);
      dst = 3'($urandom_range(0, 7)); reg_write = 1'($urandom_range(0, 1));
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("rnd_unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("rnd_result", out_result, e.res);
          chk("rnd_ofl", out_ofl, e.ofl);
          chk("rnd_dst", {out_reg_write, out_dst}, {e.wr, e.dst});
        end
      end
      hold = out_valid && !out_ready;
      held.res = out_result; held.ofl = out_ofl; held.dst = out_dst; held.wr = out_reg_write;
      if (in_valid && in_ready) begin
        ea = pick(src_a, rd_a, fw1_en, fw1_addr, fw1_data, fw2_en, fw2_addr, fw2_data);
        eb = use_imm ? imm : pick(src_b, rd_b, fw1_en, fw1_addr, fw1_data, fw2_en, fw2_addr, fw2_data);
        m = model(int'(op), longint'(ea), longint'(eb));
        e.res = m[15:0]; e.ofl = m[16]; e.dst = dst; e.wr = reg_write;
        sb.push_back(e);
      end
      step();
      if (hold)
        chk("rnd_stall_stable", {out_valid, out_ofl, out_reg_write, out_dst, out_result},
            {1'b1, held.ofl, held.wr, held.dst, held.res});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    lat = 0;
    while ((sb.size() != 0 || out_valid) && lat < 100) begin
      #1;
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("drain_unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("drain_result", {out_ofl, out_reg_write, out_dst, out_result},
              {e.ofl, e.wr, e.dst, e.res});
        end
      end
      step();
      lat++;
    end
    chk("drain_queue_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
